// File: rtl/key_cmd_queue.sv
// key_cmd_queue: latches debounced key pulses, arbitrates them by fixed
// priority (drop > rotate > left > right), encodes each as a 2-bit move
// command and buffers the commands in a small FIFO that feeds the game FSM
// over a valid/ready handshake.
module key_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_left,
  input  logic          key_right,
  input  logic          key_rot,
  input  logic          key_drop,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [1:0]    cmd_code,
  output logic [AW:0]   cmd_count,
  output logic          lost,
  input  logic          clr_lost
);

  // Bit index equals the command code: 0 left, 1 right, 2 rotate, 3 drop.
  logic [3:0]    key_vec;
  logic [3:0]    pend_reg;
  logic [3:0]    pend_next;
  logic [3:0]    sel_vec;
  logic [3:0]    clr_vec;
  logic [3:0]    loss_vec;
  logic [1:0]    sel_code;
  logic [AW-1:0] wptr_reg;
  logic [AW-1:0] rptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          lost_reg;
  logic          lost_next;
  logic          full;
  logic          empty;
  logic          pop;
  logic          wr;
  logic [1:0]    mem_reg [DEPTH];

  assign key_vec = {key_drop, key_rot, key_right, key_left};

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign pop   = ~empty & cmd_ready;

  // Fixed-priority pick among the pending bits.
  always_comb begin
    sel_code = 2'b00;
    sel_vec  = 4'b0000;
    if (pend_reg[3]) begin
      sel_code = 2'b11;
      sel_vec  = 4'b1000;
    end else if (pend_reg[2]) begin
      sel_code = 2'b10;
      sel_vec  = 4'b0100;
    end else if (pend_reg[0]) begin
      sel_code = 2'b00;
      sel_vec  = 4'b0001;
    end else if (pend_reg[1]) begin
      sel_code = 2'b01;
      sel_vec  = 4'b0010;
    end
  end

  // A full FIFO still accepts a write when its head leaves in the same cycle.
  assign wr      = (|pend_reg) & (~full | pop);
  assign clr_vec = wr ? sel_vec : 4'b0000;

  // A new press on a bit that is being written out this cycle is a new event
  // and re-arms the bit; a press on a bit that stays set is merged and lost.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pend
      assign pend_next[gi] = (pend_reg[gi] & ~clr_vec[gi]) | key_vec[gi];
      assign loss_vec[gi]  = key_vec[gi] & pend_reg[gi] & ~clr_vec[gi];
    end
  endgenerate

  // Occupancy update; a simultaneous write and pop leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    case ({wr, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // A loss in the same cycle as a clear keeps the flag set.
  always_comb begin
    lost_next = lost_reg;
    if (|loss_vec) begin
      lost_next = 1'b1;
    end else if (clr_lost) begin
      lost_next = 1'b0;
    end
  end

  // Control state: pending bits, pointers, occupancy and loss flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg  <= 4'b0000;
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      lost_reg  <= 1'b0;
    end else begin
      pend_reg  <= pend_next;
      count_reg <= count_next;
      lost_reg  <= lost_next;
      if (wr) begin
        wptr_reg <= wptr_reg + AW'(1);
      end
      if (pop) begin
        rptr_reg <= rptr_reg + AW'(1);
      end
    end
  end

  // Command storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_reg[wptr_reg] <= sel_code;
    end
  end

  assign cmd_valid = ~empty;
  assign cmd_code  = empty ? 2'b00 : mem_reg[rptr_reg];
  assign cmd_count = count_reg;
  assign lost      = lost_reg;

endmodule

// File: tb/tb_key_cmd_queue.sv
// Directed bench for key_cmd_queue: one task per scenario, inline checks.
module tb_key_cmd_queue;

  logic       clk;
  logic       rst;
  logic [3:0] keys;      // {drop, rot, right, left}; bit index = command code
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_code;
  logic [2:0] cmd_count;
  logic       lost;
  logic       clr_lost;

  int tests;
  int errs;

  key_cmd_queue #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_left  (keys[0]),
    .key_right (keys[1]),
    .key_rot   (keys[2]),
    .key_drop  (keys[3]),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_code  (cmd_code),
    .cmd_count (cmd_count),
    .lost      (lost),
    .clr_lost  (clr_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests++; if (cmd_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %0b expected 0", cmd_valid); end
    tests++; if (cmd_count !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d expected 0", cmd_count); end
    tests++; if (cmd_code !== 2'b00) begin errs++; $display("FAIL reset_code: got %0d expected 0", cmd_code); end
    tests++; if (lost !== 1'b0) begin errs++; $display("FAIL reset_lost: got %0b expected 0", lost); end
    $display("[TB] reset done");
  endtask

  task automatic test_single();
    keys = 4'b0001;   // left pulse in cycle N
    tick();
    keys = 4'b0000;
    tests++; if (cmd_valid !== 1'b0) begin errs++; $display("FAIL single_latency1: got valid %0b expected 0", cmd_valid); end
    tick();           // now in N+2
    tests++; if (cmd_valid !== 1'b1) begin errs++; $display("FAIL single_valid: got %0b expected 1", cmd_valid); end
    tests++; if (cmd_code !== 2'b00) begin errs++; $display("FAIL single_code: got %0d expected 0", cmd_code); end
    tests++; if (cmd_count !== 3'd1) begin errs++; $display("FAIL single_count: got %0d expected 1", cmd_count); end
    $display("[TB] single press: code=%0d count=%0d", cmd_code, cmd_count);
    cmd_ready = 1'b1;
    tick();
    tests++; if (cmd_valid !== 1'b0) begin errs++; $display("FAIL single_pop_valid: got %0b expected 0", cmd_valid); end
    tick();           // ready while empty must not underflow
    cmd_ready = 1'b0;
    tests++; if (cmd_count !== 3'd0) begin errs++; $display("FAIL empty_pop_count: got %0d expected 0", cmd_count); end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_codes [4];
    exp_codes[0] = 2'd3; exp_codes[1] = 2'd2; exp_codes[2] = 2'd0; exp_codes[3] = 2'd1;
    keys = 4'b1111;
    tick();
    keys = 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests++; if (cmd_count !== 3'(i)) begin errs++; $display("FAIL simul_fill%0d: got count %0d expected %0d", i, cmd_count, i); end
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (cmd_code !== exp_codes[i]) begin errs++; $display("FAIL simul_pop%0d: got code %0d expected %0d", i, cmd_code, exp_codes[i]); end
      $display("[TB] simul pop code=%0d", cmd_code);
      tick();
    end
    cmd_ready = 1'b0;
    tests++; if (cmd_valid !== 1'b0) begin errs++; $display("FAIL simul_drained: got valid %0b expected 0", cmd_valid); end
    tests++; if (lost !== 1'b0) begin errs++; $display("FAIL simul_lost: got %0b expected 0", lost); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      keys = 4'b0010;
      tick();
      keys = 4'b0000;
      tick();
      tick();
    end
    tests++; if (cmd_count !== 3'd4) begin errs++; $display("FAIL bp_full: got count %0d expected 4", cmd_count); end
    tests++; if (lost !== 1'b0) begin errs++; $display("FAIL bp_deferred_lost: got %0b expected 0", lost); end
    keys = 4'b0010;   // sixth press merges with the still-pending one
    tick();
    keys = 4'b0000;
    tests++; if (lost !== 1'b1) begin errs++; $display("FAIL bp_lost: got %0b expected 1", lost); end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tests++; if (cmd_count !== 3'd4) begin errs++; $display("FAIL bp_pop_write: got count %0d expected 4", cmd_count); end
    tick();
    tests++; if (cmd_count !== 3'd4) begin errs++; $display("FAIL bp_no_extra: got count %0d expected 4", cmd_count); end
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (cmd_code !== 2'd1) begin errs++; $display("FAIL bp_pop%0d: got code %0d expected 1", i, cmd_code); end
      tick();
    end
    cmd_ready = 1'b0;
    tests++; if (cmd_valid !== 1'b0) begin errs++; $display("FAIL bp_drained: got valid %0b expected 0", cmd_valid); end
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    tests++; if (lost !== 1'b0) begin errs++; $display("FAIL bp_clr: got %0b expected 0", lost); end
    $display("[TB] backpressure done");
  endtask

  task automatic test_full_pop_wrap();
    logic [1:0] exp_codes [4];
    for (int p = 0; p < 3; p++) begin
      // One distinct key per cycle: each enters the FIFO one cycle later.
      for (int i = 0; i < 4; i++) begin
        keys = 4'b0001 << ((p + i) % 4);
        tick();
      end
      keys = 4'b0000;
      tick();
      tests++; if (cmd_count !== 3'd4) begin errs++; $display("FAIL wrap%0d_fill: got count %0d expected 4", p, cmd_count); end
      keys = 4'b1000;   // drop stays pending behind a full FIFO
      tick();
      keys = 4'b0000;
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      tests++; if (cmd_count !== 3'd4) begin errs++; $display("FAIL wrap%0d_popwrite: got count %0d expected 4", p, cmd_count); end
      exp_codes[0] = 2'((p + 1) % 4);
      exp_codes[1] = 2'((p + 2) % 4);
      exp_codes[2] = 2'((p + 3) % 4);
      exp_codes[3] = 2'd3;
      cmd_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
        tests++; if (cmd_code !== exp_codes[j]) begin errs++; $display("FAIL wrap%0d_pop%0d: got code %0d expected %0d", p, j, cmd_code, exp_codes[j]); end
        $display("[TB] wrap pass %0d pop code=%0d", p, cmd_code);
        tick();
      end
      cmd_ready = 1'b0;
      tests++; if (cmd_valid !== 1'b0) begin errs++; $display("FAIL wrap%0d_drained: got valid %0b expected 0", p, cmd_valid); end
    end
    tests++; if (lost !== 1'b0) begin errs++; $display("FAIL wrap_lost: got %0b expected 0", lost); end
  endtask

  task automatic test_lost_clear();
    keys = 4'b1100;   // drop + rot pending
    tick();
    keys = 4'b0100;   // drop is written, rot stays set: this press merges
    clr_lost = 1'b1;
    tick();
    keys = 4'b0000;
    clr_lost = 1'b0;
    tests++; if (lost !== 1'b1) begin errs++; $display("FAIL loss_vs_clear: got %0b expected 1", lost); end
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    tests++; if (lost !== 1'b0) begin errs++; $display("FAIL clear_alone: got %0b expected 0", lost); end
    cmd_ready = 1'b1;
    tests++; if (cmd_code !== 2'd3) begin errs++; $display("FAIL lc_pop0: got code %0d expected 3", cmd_code); end
    tick();
    tests++; if (cmd_code !== 2'd2) begin errs++; $display("FAIL lc_pop1: got code %0d expected 2", cmd_code); end
    tick();
    cmd_ready = 1'b0;
    tests++; if (cmd_valid !== 1'b0) begin errs++; $display("FAIL lc_drained: got valid %0b expected 0", cmd_valid); end
  endtask

  task automatic test_reset_mid();
    keys = 4'b1101;   // drop, rot, left
    tick();
    keys = 4'b0100;   // merging rot press sets lost
    tick();
    keys = 4'b0000;
    tick();
    tick();
    tests++; if (cmd_count !== 3'd3) begin errs++; $display("FAIL rm_pre_count: got %0d expected 3", cmd_count); end
    tests++; if (lost !== 1'b1) begin errs++; $display("FAIL rm_pre_lost: got %0b expected 1", lost); end
    keys = 4'b1010;   // two pending: drop + right
    tick();
    rst = 1'b1;
    keys = 4'b0100;   // coincident with reset: ignored
    tick();
    rst = 1'b0;
    keys = 4'b0000;
    tests++; if (cmd_valid !== 1'b0) begin errs++; $display("FAIL rm_valid: got %0b expected 0", cmd_valid); end
    tests++; if (cmd_count !== 3'd0) begin errs++; $display("FAIL rm_count: got %0d expected 0", cmd_count); end
    tests++; if (lost !== 1'b0) begin errs++; $display("FAIL rm_lost: got %0b expected 0", lost); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (cmd_valid !== 1'b0) begin errs++; $display("FAIL rm_stale%0d: got valid %0b expected 0", i, cmd_valid); end
    end
    keys = 4'b0100;
    tick();
    keys = 4'b0000;
    tick();
    tests++; if (cmd_valid !== 1'b1) begin errs++; $display("FAIL rm_fresh_valid: got %0b expected 1", cmd_valid); end
    tests++; if (cmd_code !== 2'd2) begin errs++; $display("FAIL rm_fresh_code: got %0d expected 2", cmd_code); end
    tests++; if (cmd_count !== 3'd1) begin errs++; $display("FAIL rm_fresh_count: got %0d expected 1", cmd_count); end
    $display("[TB] fresh rot after reset: code=%0d", cmd_code);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tests++; if (cmd_valid !== 1'b0) begin errs++; $display("FAIL rm_drained: got valid %0b expected 0", cmd_valid); end
  endtask

  initial begin
    tests     = 0;
    errs      = 0;
    rst       = 1'b1;
    keys      = 4'b0000;
    cmd_ready = 1'b0;
    clr_lost  = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_full_pop_wrap();
    test_lost_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/key_cmd_queue.md
# key_cmd_queue

Downstream consumer of the four per-button debouncers in the Tetris input path. Each debouncer emits a one-cycle `okey` pulse per press. This block latches those pulses, arbitrates simultaneous presses by fixed priority and encodes each as a 2-bit move command. It buffers the commands in a small FIFO and hands them to the game-logic FSM over a valid/ready handshake, so no press is lost while the game FSM is busy.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `AW`, default 2: log2(`DEPTH`).

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `key_left`  in  1  one-cycle pulse from the left-button debouncer.
- `key_right`  in  1  one-cycle pulse from the right-button debouncer.
- `key_rot`  in  1  one-cycle pulse from the rotate-button debouncer.
- `key_drop`  in  1  one-cycle pulse from the drop-button debouncer.
- `cmd_valid`  out  1  FIFO non-empty.
- `cmd_ready`  in  1  consumer accepts the head entry this cycle.
- `cmd_code`  out  2  head entry: 00 left, 01 right, 10 rotate, 11 drop.
- `cmd_count`  out  AW+1  current FIFO occupancy, 0..`DEPTH`.
- `lost`  out  1  sticky flag: at least one press was discarded.
- `clr_lost`  in  1  clears `lost`.

## Operation
- **Pending latches.** There are four pending bits, one per key. A key pulse sets its bit at the next edge.
- **Arbiter.** Each cycle it selects the highest-priority set pending bit: drop > rotate > left > right.
  - It writes the selected code into the FIFO iff the FIFO is not full, or the FIFO is being popped that same cycle.
  - On a write, the selected bit clears at the edge. All other pending bits hold.
- **FIFO full, no pop.** No write occurs. Pending bits hold, so presses are deferred, not lost.
- **Pulse on an already-set pending bit:**
  - Bit is being cleared by a write this cycle: the bit stays set, because the new press is a new event. `lost` is unchanged.
  - Bit is not being cleared: the press merges and is discarded. `lost` ← 1.
- **Pop.** `cmd_valid & cmd_ready` pops the head at the edge. `cmd_ready` while empty is ignored.
- **Simultaneous write and pop.** Both occur. `cmd_count` is unchanged, including when the FIFO is full.
- **Pointers.** AW-bit read/write pointers wrap modulo `DEPTH`. Occupancy comes from the AW+1-bit `cmd_count` counter, which never exceeds `DEPTH` and never goes below 0.
- **`cmd_code` when empty.** Drives 00.
- **`lost` clear.** `clr_lost` clears `lost` at the edge. If a loss occurs in the same cycle, the loss wins and `lost` = 1.
- **Reset.** Pending bits = 0, pointers = 0, `cmd_count` = 0, `cmd_valid` = 0, `cmd_code` = 00, `lost` = 0. Reset mid-operation discards all buffered and pending commands. Key pulses coincident with `rst` are ignored.

## Timing
- **Pulse to command, empty FIFO.** Pulse in cycle N → pending set in N+1 → FIFO write at end of N+1 → `cmd_valid` = 1, `cmd_code` valid in N+2. Latency is 2 cycles.
- **Arbiter throughput.** One write per cycle. Four simultaneous pulses need four consecutive cycles to drain the pending bits.
- **Outputs.** `cmd_valid`, `cmd_code` and `cmd_count` are registered-state derived, with no combinational path from `cmd_ready`.
- **Pop.** Pop at the end of cycle M shows the next head (or `cmd_valid` = 0) in M+1.
- **Back-to-back pops.** Holding `cmd_ready` = 1 drains one entry per cycle.

## Test plan
- **Single press.** `key_left` pulse at cycle 10, `cmd_ready` = 0.
  - Required: `cmd_valid` = 1, `cmd_code` = 00 and `cmd_count` = 1 from cycle 12.
  - Then `cmd_ready` = 1 for one cycle → `cmd_valid` = 0.
- **Simultaneous presses.** All four keys pulse in the same cycle, `cmd_ready` = 0.
  - Required: FIFO fills in order 11, 10, 00, 01.
  - Popping returns drop, rotate, left, right, and `lost` = 0.
- **Backpressure.** `DEPTH` = 4, `cmd_ready` = 0.
  - Five `key_right` pulses spaced 3 cycles apart: FIFO reaches 4, then the fifth press stays pending with `lost` = 0.
  - A sixth pulse → `lost` = 1.
  - One pop → the pending right is written and `cmd_count` stays 4.
- **Full plus pop.** FIFO full, pending drop set, `cmd_ready` = 1.
  - Required: pop and write in the same cycle; `cmd_count` = 4; drop is the newest entry.
  - Pointers wrap correctly over 3 full passes.
- **Loss vs clear.** `clr_lost` asserted in the same cycle as a merging pulse → `lost` = 1. `clr_lost` alone next cycle → `lost` = 0.
- **Reset mid-operation.** `rst` for 1 cycle with 3 buffered entries and 2 pending bits.
  - Required: next cycle `cmd_valid` = 0, `cmd_count` = 0, `lost` = 0.
  - No stale command ever appears; a fresh `key_rot` gives code 10 after 2 cycles.
